// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, talks to instruction memory and
// hands one registered instruction per cycle to EX, with redirect and squash.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_src_EX,
  input  logic        stall_FETCH,
  input  logic [15:0] branch_offset_EX,
  input  logic [25:0] jump_index_EX,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_EX,
  output logic [31:0] pc_EX,
  output logic        valid_EX
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    S_FETCH    = 1'b0,
    S_REDIRECT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_f_q, pc_f_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_ex_q, pc_ex_d;
  logic              valid_q, valid_d;

  logic              redirect;
  logic [XLEN-1:0]   pc_ex_plus4;
  logic [XLEN-1:0]   branch_target;
  logic [XLEN-1:0]   jump_target;
  logic [XLEN-1:0]   redirect_target;

  // Only a real instruction in EX may steer the fetch PC.
  assign redirect      = valid_q && ((pc_src_EX == 2'd1) || (pc_src_EX == 2'd2));
  assign pc_ex_plus4   = pc_ex_q + XLEN'(4);
  assign branch_target = pc_ex_plus4 + {{14{branch_offset_EX[15]}}, branch_offset_EX, 2'b00};
  assign jump_target   = {pc_ex_plus4[31:28], jump_index_EX, 2'b00};
  assign redirect_target = (pc_src_EX == 2'd2) ? jump_target : branch_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_f_q  <= RESET_PC;
      instr_q <= NOP_WORD;
      pc_ex_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      instr_q <= instr_d;
      pc_ex_q <= pc_ex_d;
      valid_q <= valid_d;
    end
  end

  // Priority: redirect, then squash, then normal capture; everything else bubbles.
  always_comb begin
    state_d = S_FETCH;
    pc_f_d  = pc_f_q;
    instr_d = NOP_WORD;
    pc_ex_d = pc_ex_q;
    valid_d = 1'b0;
    if (redirect) begin
      state_d = S_REDIRECT;
      pc_f_d  = redirect_target;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!stall_FETCH && imem_ready) begin
            instr_d = imem_rdata;
            pc_ex_d = pc_f_q;
            valid_d = 1'b1;
            pc_f_d  = pc_f_q + XLEN'(4);
          end
        end
        S_REDIRECT: state_d = S_FETCH;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  assign imem_req       = (state_q == S_FETCH) && !rst;
  assign imem_addr      = pc_f_q[13:2];
  assign instruction_EX = instr_q;
  assign pc_EX          = pc_ex_q;
  assign valid_EX       = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: three instances (default reset PC, wrapping
// reset PC, high reset PC for jump region) fed from a word-address echo memory.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_src;
  logic [1:0]  pc_src_c;
  logic        stall;
  logic [15:0] off;
  logic [25:0] idx;
  logic        ready;

  logic        req_a, req_b, req_c;
  logic [11:0] addr_a, addr_b, addr_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic [31:0] instr_a, instr_b, instr_c;
  logic [31:0] pcex_a, pcex_b, pcex_c;
  logic        valid_a, valid_b, valid_c;

  int checks;
  int failures;

  assign rdata_a = {20'h0, addr_a};
  assign rdata_b = {20'h0, addr_b};
  assign rdata_c = {20'h0, addr_c};

  fetch_stage u_a (
    .clk(clk), .rst(rst), .pc_src_EX(pc_src), .stall_FETCH(stall),
    .branch_offset_EX(off), .jump_index_EX(idx),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ready(ready), .imem_rdata(rdata_a),
    .instruction_EX(instr_a), .pc_EX(pcex_a), .valid_EX(valid_a)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_b (
    .clk(clk), .rst(rst), .pc_src_EX(pc_src), .stall_FETCH(stall),
    .branch_offset_EX(off), .jump_index_EX(idx),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ready(ready), .imem_rdata(rdata_b),
    .instruction_EX(instr_b), .pc_EX(pcex_b), .valid_EX(valid_b)
  );

  fetch_stage #(.RESET_PC(32'h2000_0000)) u_c (
    .clk(clk), .rst(rst), .pc_src_EX(pc_src_c), .stall_FETCH(stall),
    .branch_offset_EX(off), .jump_index_EX(idx),
    .imem_req(req_c), .imem_addr(addr_c), .imem_ready(ready), .imem_rdata(rdata_c),
    .instruction_EX(instr_c), .pc_EX(pcex_c), .valid_EX(valid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex_a(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic vld);
    chk({tag, "_instr"}, instr_a, ins);
    chk({tag, "_pc"}, pcex_a, pc);
    chk({tag, "_valid"}, 32'(valid_a), 32'(vld));
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; pc_src = 2'd0; pc_src_c = 2'd0; stall = 1'b0;
    off = 16'h0; idx = 26'h0; ready = 1'b0;

    // reset
    step(); step();
    chk_ex_a("rst", 32'h0, 32'h0, 1'b0);
    chk("rst_req", 32'(req_a), 32'h0);
    rst = 1'b0; ready = 1'b1;
    #1;
    chk("first_req", 32'(req_a), 32'h1);
    chk("first_addr", 32'(addr_a), 32'h0);

    // sequential fetch
    step();
    chk_ex_a("seq0", 32'h0, 32'h0, 1'b1);
    chk("seq0_addr", 32'(addr_a), 32'h1);
    step();
    chk_ex_a("seq1", 32'h1, 32'h4, 1'b1);

    // three wait states at pc 0x8
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_valid", 32'(valid_a), 32'h0);
      chk("wait_addr", 32'(addr_a), 32'h2);
      chk("wait_req", 32'(req_a), 32'h1);
    end
    ready = 1'b1;
    step();
    chk_ex_a("after_wait", 32'h2, 32'h8, 1'b1);

    // squash at pc 0xC, then refetch
    stall = 1'b1;
    step();
    chk("squash_valid", 32'(valid_a), 32'h0);
    chk("squash_instr", instr_a, 32'h0);
    chk("squash_addr", 32'(addr_a), 32'h3);
    stall = 1'b0;
    step();
    chk_ex_a("refetch", 32'h3, 32'hC, 1'b1);
    step();
    chk_ex_a("seq4", 32'h4, 32'h10, 1'b1);

    // branch from 0x10 with offset -4 words, racing a squash: branch wins
    pc_src = 2'd1; off = 16'hFFFC; stall = 1'b1;
    step();
    pc_src = 2'd0; stall = 1'b0;
    chk("br_valid", 32'(valid_a), 32'h0);
    chk("br_req", 32'(req_a), 32'h0);
    chk("br_addr", 32'(addr_a), 32'h1);
    step();
    chk("br_bubble2", 32'(valid_a), 32'h0);
    chk("br_req2", 32'(req_a), 32'h1);
    chk("br_addr2", 32'(addr_a), 32'h1);
    // jump request while EX holds a bubble must be ignored
    pc_src = 2'd2; idx = 26'h40;
    step();
    pc_src = 2'd0;
    chk_ex_a("br_target", 32'h1, 32'h4, 1'b1);
    chk("nojump_addr", 32'(addr_a), 32'h2);

    // branch +1 word from 0x4, then reset in the REDIRECT cycle
    pc_src = 2'd1; off = 16'h0001;
    step();
    pc_src = 2'd0;
    chk("br2_addr", 32'(addr_a), 32'h3);
    rst = 1'b1;
    step();
    chk_ex_a("rst_redir", 32'h0, 32'h0, 1'b0);
    chk("rst_redir_req", 32'(req_a), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", 32'(req_a), 32'h1);
    chk("post_rst_addr", 32'(addr_a), 32'h0);
    chk("b_rst_addr", 32'(addr_b), 32'hFFF);
    chk("c_rst_addr", 32'(addr_c), 32'h0);

    // wrap on B, jump on C
    step();
    chk("b_pc", pcex_b, 32'hFFFF_FFFC);
    chk("b_instr", instr_b, 32'h0000_0FFF);
    chk("b_wrap_addr", 32'(addr_b), 32'h0);
    chk("c_pc", pcex_c, 32'h2000_0000);
    chk("c_valid", 32'(valid_c), 32'h1);
    pc_src_c = 2'd2; idx = 26'h40;
    step();
    pc_src_c = 2'd0;
    chk("b_wrap_pc", pcex_b, 32'h0);
    chk("c_jmp_valid", 32'(valid_c), 32'h0);
    chk("c_jmp_req", 32'(req_c), 32'h0);
    chk("c_jmp_addr", 32'(addr_c), 32'h40);
    step();
    chk("c_jmp_bubble", 32'(valid_c), 32'h0);
    step();
    chk("c_jmp_pc", pcex_c, 32'h2000_0100);
    chk("c_jmp_instr", instr_c, 32'h40);
    chk("c_jmp_valid2", 32'(valid_c), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h0000_0000, giving the instruction word presented for a bubble.
REQ-003 The block SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port pc_src_EX, input, 2, redirect select: 0 sequential, 1 branch, 2 jump, 3 treated as 0.
REQ-006 The block SHALL have port stall_FETCH, input, 1, squash request: the word captured this cycle becomes a bubble.
REQ-007 The block SHALL have port branch_offset_EX, input, 16, signed word offset, instruction_EX[15:0].
REQ-008 The block SHALL have port jump_index_EX, input, 26, jump word index, instruction_EX[25:0].
REQ-009 The block SHALL have port imem_req, output, 1, instruction memory read request.
REQ-010 The block SHALL have port imem_addr, output, 12, word address, equal to pc_F[13:2].
REQ-011 The block SHALL have port imem_ready, input, 1, memory has valid imem_rdata this cycle.
REQ-012 The block SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-013 The block SHALL have port instruction_EX, output, 32, registered instruction to the execute stage.
REQ-014 The block SHALL have port pc_EX, output, 32, registered PC of instruction_EX.
REQ-015 The block SHALL have port valid_EX, output, 1, instruction_EX is a real instruction, not a bubble.

Function
REQ-016 The block SHALL hold an internal 32-bit fetch PC pc_F and a 2-state FSM: FETCH (imem_req=1) and REDIRECT (imem_req=0).
REQ-017 In FETCH with imem_ready=1 and no redirect/squash, the block SHALL capture instruction_EX<=imem_rdata, pc_EX<=pc_F, valid_EX<=1, and pc_F<=pc_F+4.
REQ-018 In FETCH with imem_ready=0, the block SHALL hold pc_F, keep imem_req and imem_addr stable, and load instruction_EX<=NOP_WORD, valid_EX<=0.
REQ-019 Redirect occurs when valid_EX=1 and pc_src_EX is 1 or 2; invalid EX instructions SHALL never redirect.
REQ-020 The branch target SHALL be pc_EX+4+(sign-extended branch_offset_EX<<2), modulo 2^32.
REQ-021 The jump target SHALL be {(pc_EX+4)[31:28], jump_index_EX, 2'b00}.
REQ-022 On redirect, pc_F SHALL load the target, the FSM SHALL enter REDIRECT for exactly one cycle, and any word returned that cycle SHALL be discarded, with instruction_EX<=NOP_WORD and valid_EX<=0.
REQ-023 In REDIRECT, the block SHALL drive a bubble to EX, hold pc_F, and return to FETCH next cycle.
REQ-024 On stall_FETCH=1 without redirect, the captured word SHALL become a bubble (NOP_WORD, valid_EX=0) and pc_F SHALL NOT advance, so the same address is re-fetched.
REQ-025 Redirect SHALL take priority over stall_FETCH, and stall_FETCH SHALL take priority over a normal capture.
REQ-026 pc_F+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000; imem_addr SHALL wrap modulo 4096 words.
REQ-027 Minimum fetch latency SHALL be 1 cycle (imem_ready in the same cycle as the request), with one instruction per cycle sustained.

Reset
REQ-028 While rst=1, the block SHALL load pc_F<=RESET_PC, FSM<=FETCH, instruction_EX<=NOP_WORD, pc_EX<=32'h0, and valid_EX<=0.
REQ-029 Reset SHALL override every other input, including mid-wait and mid-redirect; imem_req SHALL be 0 while rst=1.
REQ-030 On the first cycle after rst deasserts, the block SHALL drive imem_req=1 with imem_addr=RESET_PC[13:2].

Verification
REQ-031 Sequential fetch: reset, then imem_ready=1 each cycle with rdata=addr -> instruction_EX = 0,1,2,...; pc_EX = 0,4,8,...; valid_EX=1 from cycle 2.
REQ-032 Wait states: imem_ready=0 for 3 cycles at pc 0x8 -> 3 bubbles, imem_addr held at 2, then pc_EX=0x8 is captured.
REQ-033 Branch: pc_EX=0x10, valid_EX=1, pc_src_EX=1, offset=16'hFFFC -> next fetch address 0x4 after one REDIRECT bubble, with the in-flight word discarded.
REQ-034 Jump: pc_EX=0x2000_0000, pc_src_EX=2, index=26'h40 -> pc_F=0x2000_0100; pc_src_EX=2 with valid_EX=0 -> no redirect.
REQ-035 Squash: stall_FETCH=1 for one cycle at pc 0xC -> one bubble, then 0xC is re-fetched; with simultaneous pc_src_EX=1, the branch wins.
REQ-036 Wrap and reset: RESET_PC=32'hFFFF_FFFC -> next pc_F=0; rst asserted during REDIRECT -> outputs at reset values next cycle.
